uart_tx_param: RTL and testbench

Parametrised single-clock UART transmitter with an integrated write FIFO, programmable baud divider, data width, parity and stop bits. It replaces the fixed 8N1 transmitter/FIFO pair and their separate UART clock: one system clock feeds the FIFO, and an internal divider times the bits. It sits between a byte producer using a put/full push interface and the serial TX pin, with CTS flow control.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_param_if.sv | 19 +
 rtl/uart_fifo.sv | 71 +++++++
 rtl/uart_tx_param.sv | 159 +++++++++++++++
 tb/tb_uart_tx_param.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// FSM state encoding and the FIFO occupancy width helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side bundle of the UART transmitter: push interface, flow control
// and line/status outputs.
interface uart_tx_param_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 8
) ();
    logic [DATA_BITS-1:0]          in;
    logic                          put;
    logic                          full;
    logic [count_width(DEPTH)-1:0] count;
    logic                          cts;
    logic                          busy;
    logic                          tx;

    modport master (output in, put, cts, input full, count, busy, tx);
    modport slave  (input in, put, cts, output full, count, busy, tx);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with put/full write side, get/empty read side and a
// registered occupancy count from which full and empty are derived.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_put,
    output logic                          o_full,
    input  logic                          i_get,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_empty,
    output logic [count_width(DEPTH)-1:0] o_count
);
    localparam int CW = count_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic [CW-1:0]    w_count_next;
    logic             w_push;
    logic             w_pop;

    // A put while full is dropped even if a pop frees a slot on the same edge.
    assign w_push  = i_put && !r_full;
    assign w_pop   = i_get && (r_count != {CW{1'b0}});
    assign o_full  = r_full;
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Occupancy after this edge's push/pop.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_full   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Single-clock UART transmitter: FIFO-fed frame FSM with a per-bit countdown
// timer, LSB-first shift register, optional parity and 1/2 stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1,
    parameter int DIV       = 16,
    parameter int DEPTH     = 8
) (
    input  logic           clock,
    input  logic           reset,
    uart_tx_param_if.slave bus
);
    localparam int CW = count_width(DEPTH);
    localparam int TW = $clog2(DIV);
    localparam int BW = 4;

    tx_state_e            r_state;
    tx_state_e            w_next_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_busy;
    logic                 w_tx_next;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [CW-1:0]        w_count;
    logic                 w_bit_end;
    logic                 w_start_ok;
    logic                 w_last_data;
    logic                 w_last_stop;

    uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .i_data  (bus.in),
        .i_put   (bus.put),
        .o_full  (w_full),
        .i_get   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_bit_end   = (r_timer == {TW{1'b0}});
    assign w_start_ok  = !w_empty && !bus.cts;
    assign w_last_data = (r_bit_cnt == BW'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_cnt == BW'(STOP_BITS - 1));
    assign bus.tx      = r_tx;
    assign bus.busy    = r_busy;
    assign bus.full    = w_full;
    assign bus.count   = w_count;

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Next state, FIFO pop and the line level of the bit being entered.
    always_comb begin
        w_next_state = r_state;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tx_next = 1'b1;
                if (w_start_ok) begin
                    w_next_state = ST_START;
                    w_pop        = 1'b1;
                    w_tx_next    = 1'b0;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_next_state = ST_DATA;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_next_state = ST_START;
                end
            end
            ST_DATA: begin
                if (w_bit_end && w_last_data) begin
                    if (PARITY != PARITY_NONE) begin
                        w_next_state = ST_PARITY;
                        w_tx_next    = r_par ^ r_shift[0];
                    end else begin
                        w_next_state = ST_STOP;
                        w_tx_next    = 1'b1;
                    end
                end else if (w_bit_end) begin
                    w_tx_next = r_shift[1];
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_next_state = ST_STOP;
                    w_tx_next    = 1'b1;
                end else begin
                    w_next_state = ST_PARITY;
                end
            end
            ST_STOP: begin
                // cts is only looked at here and in IDLE, so frames are never cut short.
                if (w_bit_end && w_last_stop && w_start_ok) begin
                    w_next_state = ST_START;
                    w_pop        = 1'b1;
                    w_tx_next    = 1'b0;
                end else if (w_bit_end && w_last_stop) begin
                    w_next_state = ST_IDLE;
                    w_tx_next    = 1'b1;
                end else begin
                    w_tx_next = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // Datapath: line/busy registers, bit timer, bit counter, shifter, parity.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_timer   <= {TW{1'b0}};
            r_bit_cnt <= {BW{1'b0}};
            r_shift   <= {DATA_BITS{1'b0}};
            r_par     <= 1'b0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= (w_next_state != ST_IDLE);
            if (w_pop || (w_bit_end && r_state != ST_IDLE)) r_timer <= TW'(DIV - 1);
            else if (r_state != ST_IDLE)                    r_timer <= r_timer - TW'(1);
            if (w_next_state != r_state)                               r_bit_cnt <= {BW{1'b0}};
            else if (w_bit_end && (r_state == ST_DATA || r_state == ST_STOP)) r_bit_cnt <= r_bit_cnt + BW'(1);
            if (w_pop) begin
                r_shift <= w_fifo_data;
                r_par   <= (PARITY == PARITY_ODD);
            end else if (r_state == ST_DATA && w_bit_end) begin
                r_shift <= r_shift >> 1;
                r_par   <= r_par ^ r_shift[0];
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: five parameter sets, words queued on put
// and checked against frames decoded from the tx line.
module tb_uart_tx_param;
    localparam int DIV = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         sel    = 0;
    logic [8:0] sb_q[$];
    logic       tx_s, busy_s, full_s;
    int         count_s;

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8), .DEPTH(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8), .DEPTH(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(8), .DEPTH(8)) if2 ();
    uart_tx_param_if #(.DATA_BITS(7), .DEPTH(8)) if3 ();
    uart_tx_param_if #(.DATA_BITS(8), .DEPTH(4)) if4 ();

    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV(DIV), .DEPTH(8))
        u_8n1 (.clock(clk), .reset(rst_n), .bus(if0.slave));
    uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV(DIV), .DEPTH(8))
        u_8e1 (.clock(clk), .reset(rst_n), .bus(if1.slave));
    uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV(DIV), .DEPTH(8))
        u_8o1 (.clock(clk), .reset(rst_n), .bus(if2.slave));
    uart_tx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DIV(DIV), .DEPTH(8))
        u_7o2 (.clock(clk), .reset(rst_n), .bus(if3.slave));
    uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV(DIV), .DEPTH(4))
        u_wrap (.clock(clk), .reset(rst_n), .bus(if4.slave));

    always_comb begin
        case (sel)
            0:       begin tx_s = if0.tx; busy_s = if0.busy; full_s = if0.full; count_s = int'(if0.count); end
            1:       begin tx_s = if1.tx; busy_s = if1.busy; full_s = if1.full; count_s = int'(if1.count); end
            2:       begin tx_s = if2.tx; busy_s = if2.busy; full_s = if2.full; count_s = int'(if2.count); end
            3:       begin tx_s = if3.tx; busy_s = if3.busy; full_s = if3.full; count_s = int'(if3.count); end
            default: begin tx_s = if4.tx; busy_s = if4.busy; full_s = if4.full; count_s = int'(if4.count); end
        endcase
    end

    task automatic put_word(input int dut, input logic [8:0] w);
        case (dut)
            0:       begin if0.in = w[7:0]; if0.put = 1'b1; end
            1:       begin if1.in = w[7:0]; if1.put = 1'b1; end
            2:       begin if2.in = w[7:0]; if2.put = 1'b1; end
            3:       begin if3.in = w[6:0]; if3.put = 1'b1; end
            default: begin if4.in = w[7:0]; if4.put = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if0.put = 1'b0; if1.put = 1'b0; if2.put = 1'b0; if3.put = 1'b0; if4.put = 1'b0;
        @(negedge clk);
    endtask

    // Waits for a start bit, then samples DIV negedges per bit; waited=-1 on timeout.
    task automatic rx_frame(input int nb, input int np, input int ns,
                            output logic [8:0] d, output logic p, output logic stop_ok,
                            output logic stable, output int waited, output int busy_n);
        int   nbits;
        logic v;
        nbits = 1 + nb + np + ns;
        d = 9'h000; p = 1'b0; stop_ok = 1'b1; stable = 1'b1; waited = 0; busy_n = 0;
        while (tx_s !== 1'b0 && waited < 600) begin
            @(negedge clk);
            waited++;
        end
        if (tx_s !== 1'b0) begin
            waited = -1;
            return;
        end
        for (int i = 0; i < nbits; i++) begin
            v = tx_s;
            for (int c = 0; c < DIV; c++) begin
                if (tx_s !== v) stable = 1'b0;
                if (busy_s === 1'b1) busy_n++;
                @(negedge clk);
            end
            if (i == 0) begin
                if (v !== 1'b0) stable = 1'b0;
            end else if (i <= nb) begin
                d[i-1] = v;
            end else if (np != 0 && i == nb + 1) begin
                p = v;
            end else if (v !== 1'b1) begin
                stop_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 5; s++) begin
            sel = s;
            #1;
            checks++; if (tx_s !== 1'b1)   begin errors++; $display("FAIL reset_tx dut%0d got %b exp 1", s, tx_s); end
            checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d got %b exp 0", s, busy_s); end
            checks++; if (full_s !== 1'b0) begin errors++; $display("FAIL reset_full dut%0d got %b exp 0", s, full_s); end
            checks++; if (count_s != 0)    begin errors++; $display("FAIL reset_count dut%0d got %0d exp 0", s, count_s); end
        end
    endtask

    task automatic test_8n1();
        logic [8:0] d, e; logic p, sok, stb; int w, bn;
        sel = 0; if0.cts = 1'b0;
        @(negedge clk);
        put_word(0, 9'h048); sb_q.push_back(9'h048);
        checks++; if (count_s != 1)   begin errors++; $display("FAIL 8n1_count_k got %0d exp 1", count_s); end
        checks++; if (tx_s !== 1'b1)  begin errors++; $display("FAIL 8n1_tx_k got %b exp 1", tx_s); end
        @(negedge clk);
        checks++; if (tx_s !== 1'b0)  begin errors++; $display("FAIL 8n1_start_k1 got %b exp 0", tx_s); end
        checks++; if (count_s != 0)   begin errors++; $display("FAIL 8n1_count_k1 got %0d exp 0", count_s); end
        checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL 8n1_busy_k1 got %b exp 1", busy_s); end
        rx_frame(8, 0, 1, d, p, sok, stb, w, bn);
        e = sb_q.pop_front();
        checks++; if (d !== e)        begin errors++; $display("FAIL 8n1_data got %h exp %h", d, e); end
        checks++; if (bn != 40)       begin errors++; $display("FAIL 8n1_busy_len got %0d exp 40", bn); end
        checks++; if (!(sok && stb && w == 0)) begin errors++; $display("FAIL 8n1_framing stop %b stable %b wait %0d exp 1 1 0", sok, stb, w); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL 8n1_busy_end got %b exp 0", busy_s); end
    endtask

    task automatic test_parity();
        int         dut_t[3] = '{1, 2, 3};
        int         nb_t[3]  = '{8, 8, 7};
        int         ns_t[3]  = '{1, 1, 2};
        logic [8:0] wd_t[3]  = '{9'h048, 9'h048, 9'h07F};
        logic       par_t[3] = '{1'b0, 1'b1, 1'b0};
        logic [8:0] d, e; logic p, sok, stb; int w, bn;
        if1.cts = 1'b0; if2.cts = 1'b0; if3.cts = 1'b0;
        for (int t = 0; t < 3; t++) begin
            sel = dut_t[t];
            @(negedge clk);
            put_word(dut_t[t], wd_t[t]); sb_q.push_back(wd_t[t]);
            rx_frame(nb_t[t], 1, ns_t[t], d, p, sok, stb, w, bn);
            e = sb_q.pop_front();
            checks++; if (d !== e)         begin errors++; $display("FAIL par_data dut%0d got %h exp %h", sel, d, e); end
            checks++; if (p !== par_t[t])  begin errors++; $display("FAIL par_bit dut%0d got %b exp %b", sel, p, par_t[t]); end
            checks++; if (bn != 44)        begin errors++; $display("FAIL par_len dut%0d got %0d exp 44", sel, bn); end
            checks++; if (!(sok && stb && w == 1 && busy_s === 1'b0)) begin errors++; $display("FAIL par_framing dut%0d stop %b stable %b wait %0d busy %b exp 1 1 1 0", sel, sok, stb, w, busy_s); end
        end
    endtask

    task automatic test_full_drop();
        logic [8:0] d, e; logic p, sok, stb; int w, bn; int model; logic bad;
        sel = 0; if0.cts = 1'b1; model = 0;
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            put_word(0, 9'(16 + i));
            if (model < 8) begin sb_q.push_back(9'(16 + i)); model++; end
            if (i == 6) begin
                checks++; if (full_s !== 1'b0 || count_s != 7) begin errors++; $display("FAIL fill7 full %b count %0d exp 0 7", full_s, count_s); end
            end
            if (i >= 7) begin
                checks++; if (full_s !== 1'b1 || count_s != model) begin errors++; $display("FAIL fill_full put%0d full %b count %0d exp 1 %0d", i, full_s, count_s, model); end
            end
        end
        repeat (10) @(negedge clk);
        checks++; if (tx_s !== 1'b1 || busy_s !== 1'b0) begin errors++; $display("FAIL cts_hold tx %b busy %b exp 1 0", tx_s, busy_s); end
        if0.cts = 1'b0;
        for (int f = 0; f < 8; f++) begin
            rx_frame(8, 0, 1, d, p, sok, stb, w, bn);
            e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
            checks++; if (d !== e) begin errors++; $display("FAIL b2b_data frame%0d got %h exp %h", f, d, e); end
            checks++; if (!(sok && stb && w == ((f == 0) ? 1 : 0))) begin errors++; $display("FAIL b2b_framing frame%0d stop %b stable %b wait %0d exp 1 1 %0d", f, sok, stb, w, (f == 0) ? 1 : 0); end
        end
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (tx_s !== 1'b1 || busy_s !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++; if (bad !== 1'b0 || count_s != 0) begin errors++; $display("FAIL dropped_word idle_bad %b count %0d exp 0 0", bad, count_s); end
    endtask

    task automatic test_cts_mid();
        logic [8:0] d, e; logic p, sok, stb; int w, bn;
        sel = 0; if0.cts = 1'b0;
        @(negedge clk);
        put_word(0, 9'h0A5); sb_q.push_back(9'h0A5);
        put_word(0, 9'h03C); sb_q.push_back(9'h03C);
        fork
            rx_frame(8, 0, 1, d, p, sok, stb, w, bn);
            begin repeat (12) @(negedge clk); if0.cts = 1'b1; end
        join
        e = sb_q.pop_front();
        checks++; if (d !== e || bn != 40 || !(sok && stb)) begin errors++; $display("FAIL cts_frame1 data %h len %0d stop %b stable %b exp %h 40 1 1", d, bn, sok, stb, e); end
        checks++; if (busy_s !== 1'b0 || tx_s !== 1'b1 || count_s != 1) begin errors++; $display("FAIL cts_idle busy %b tx %b count %0d exp 0 1 1", busy_s, tx_s, count_s); end
        repeat (20) @(negedge clk);
        checks++; if (busy_s !== 1'b0 || count_s != 1) begin errors++; $display("FAIL cts_wait busy %b count %0d exp 0 1", busy_s, count_s); end
        if0.cts = 1'b0;
        rx_frame(8, 0, 1, d, p, sok, stb, w, bn);
        e = sb_q.pop_front();
        checks++; if (d !== e || w != 1 || !(sok && stb)) begin errors++; $display("FAIL cts_frame2 data %h wait %0d stop %b stable %b exp %h 1 1 1", d, w, sok, stb, e); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] d, e; logic p, sok, stb; int w, bn; logic bad;
        sel = 0; if0.cts = 1'b0;
        @(negedge clk);
        put_word(0, 9'h055);
        put_word(0, 9'h033);
        repeat (8) @(negedge clk);
        checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", busy_s); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_s !== 1'b1 || busy_s !== 1'b0 || count_s != 0) begin errors++; $display("FAIL rst_async tx %b busy %b count %0d exp 1 0 0", tx_s, busy_s, count_s); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_s !== 1'b1 || busy_s !== 1'b0 || count_s != 0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_discard got %b exp 0", bad); end
        put_word(0, 9'h0A5); sb_q.push_back(9'h0A5);
        rx_frame(8, 0, 1, d, p, sok, stb, w, bn);
        e = sb_q.pop_front();
        checks++; if (d !== e || w != 1 || bn != 40 || !(sok && stb)) begin errors++; $display("FAIL rst_clean data %h wait %0d len %0d stop %b stable %b exp %h 1 40 1 1", d, w, bn, sok, stb, e); end
    endtask

    task automatic test_back_to_back_wrap();
        sel = 4; if4.cts = 1'b0;
        @(negedge clk);
        fork
            begin
                int i = 0;
                int guard = 0;
                while (i < 20 && guard < 5000) begin
                    if (full_s === 1'b0) begin
                        put_word(4, 9'(48 + i));
                        sb_q.push_back(9'(48 + i));
                        i++;
                    end else begin
                        @(negedge clk);
                    end
                    guard++;
                end
            end
            begin
                logic [8:0] d, e; logic p, sok, stb; int w, bn;
                for (int f = 0; f < 20; f++) begin
                    rx_frame(8, 0, 1, d, p, sok, stb, w, bn);
                    e = (sb_q.size() > 0) ? sb_q.pop_front() : 9'h1FF;
                    checks++; if (d !== e || w < 0 || !(sok && stb)) begin errors++; $display("FAIL wrap frame%0d data %h exp %h wait %0d stop %b stable %b", f, d, e, w, sok, stb); end
                end
            end
        join
        checks++; if (sb_q.size() != 0 || count_s != 0) begin errors++; $display("FAIL wrap_drain queued %0d count %0d exp 0 0", sb_q.size(), count_s); end
    endtask

    initial begin
        if0.in = 8'h00; if0.put = 1'b0; if0.cts = 1'b0;
        if1.in = 8'h00; if1.put = 1'b0; if1.cts = 1'b0;
        if2.in = 8'h00; if2.put = 1'b0; if2.cts = 1'b0;
        if3.in = 7'h00; if3.put = 1'b0; if3.cts = 1'b0;
        if4.in = 8'h00; if4.put = 1'b0; if4.cts = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_8n1();
        test_parity();
        test_full_drop();
        test_cts_mid();
        test_reset_mid();
        test_back_to_back_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
